// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator array: width derivation,
// legal ORDER range and clamping of the requested decimation exponent.
package cic_pkg;

  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 4;

  function automatic int calc_out_w(input int order, input int max_log2);
    return order * max_log2 + 1;
  endfunction

  // A single channel still needs a 1-bit select port.
  function automatic int calc_sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic logic [3:0] clamp_decim(input logic [3:0] d, input int max_log2);
    if (d == 4'd0) return 4'd1;
    if (int'(d) > max_log2) return 4'(max_log2);
    return d;
  endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC decimator lane: ORDER integrators at the input rate, ORDER combs
// evaluated only on the frame-end cycle and registered into out.
module cic_channel
  import cic_pkg::*;
#(
  parameter int ORDER = 3,
  parameter int OUT_W = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             dump,
  input  logic             in,
  output logic [OUT_W-1:0] out
);

  logic [OUT_W-1:0] integ    [ORDER];
  logic [OUT_W-1:0] comb_dly [ORDER];
  logic [OUT_W-1:0] comb_in  [ORDER];
  logic [OUT_W-1:0] comb_out;

  // comb_in[i] is the value entering comb stage i; it becomes that stage's delay.
  always_comb begin
    logic [OUT_W-1:0] acc;
    acc = integ[ORDER-1];
    for (int i = 0; i < ORDER; i++) begin
      comb_in[i] = acc;
      acc        = acc - comb_dly[i];
    end
    comb_out = acc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ORDER; i++) begin
        integ[i]    <= '0;
        comb_dly[i] <= '0;
      end
      out <= '0;
    end else if (enable) begin
      integ[0] <= integ[0] + OUT_W'(in);
      for (int i = 1; i < ORDER; i++) begin
        integ[i] <= integ[i] + integ[i-1];
      end
      if (dump) begin
        for (int i = 0; i < ORDER; i++) begin
          comb_dly[i] <= comb_in[i];
        end
        out <= comb_out;
      end
    end
  end

endmodule

// File: rtl/cic_decim_array.sv
// Array of NUM_CH CIC decimators sharing one frame counter, a run-time
// decimation exponent latched at frame boundaries, and a channel monitor mux.
module cic_decim_array
  import cic_pkg::*;
#(
  parameter int NUM_CH         = 24,
  parameter int ORDER          = 3,
  parameter int MAX_DECIM_LOG2 = 8,
  localparam int OUT_W         = calc_out_w(ORDER, MAX_DECIM_LOG2),
  localparam int SEL_W         = calc_sel_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       in,
  input  logic [3:0]              decim_log2,
  input  logic [SEL_W-1:0]        digital_monitor_sel,
  output logic [NUM_CH*OUT_W-1:0] out,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        monitor_out,
  output logic [3:0]              active_decim_log2
);

  localparam int CNT_W = MAX_DECIM_LOG2;

  if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
    $error("cic_decim_array: ORDER out of legal range");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             frame_end;
  logic [OUT_W-1:0] mon_next;

  assign last_cnt  = CNT_W'((32'd1 << active_decim_log2) - 32'd1);
  assign frame_end = enable && (cnt == last_cnt);

  // out_valid is a pure strobe with no backpressure: high for exactly the one
  // cycle after out is loaded, and out stays stable until the next strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt               <= '0;
      out_valid         <= 1'b0;
      active_decim_log2 <= clamp_decim(decim_log2, MAX_DECIM_LOG2);
    end else begin
      out_valid <= frame_end;
      if (enable) begin
        if (frame_end) begin
          cnt               <= '0;
          active_decim_log2 <= clamp_decim(decim_log2, MAX_DECIM_LOG2);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cic_channel #(
      .ORDER (ORDER),
      .OUT_W (OUT_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .dump    (frame_end),
      .in      (in[k]),
      .out     (out[k*OUT_W +: OUT_W])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    mon_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(digital_monitor_sel) == k) mon_next = out[k*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) monitor_out <= '0;
    else          monitor_out <= mon_next;
  end

endmodule

// File: tb/tb_cic_decim_array.sv
// Bench for cic_decim_array: behavioural CIC model (running sums plus an
// N-th finite difference of the decimated samples) checked every cycle.
module tb_cic_decim_array;

  localparam int NUM_CH = 24;
  localparam int ORDER  = 3;
  localparam int MAXL   = 8;
  localparam int OUT_W  = ORDER * MAXL + 1;
  localparam int SEL_W  = $clog2(NUM_CH);

  // clock / reset
  logic clk;
  logic reset_n;
  logic enable;
  logic [NUM_CH-1:0] in;
  logic [3:0] decim_log2;
  logic [SEL_W-1:0] digital_monitor_sel;
  logic [NUM_CH*OUT_W-1:0] out;
  logic out_valid;
  logic [OUT_W-1:0] monitor_out;
  logic [3:0] active_decim_log2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  cic_decim_array #(.NUM_CH(NUM_CH), .ORDER(ORDER), .MAX_DECIM_LOG2(MAXL)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .in                  (in),
    .decim_log2          (decim_log2),
    .digital_monitor_sel (digital_monitor_sel),
    .out                 (out),
    .out_valid           (out_valid),
    .monitor_out         (monitor_out),
    .active_decim_log2   (active_decim_log2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W-1:0] fld(input int k);
    return out[k*OUT_W +: OUT_W];
  endfunction

  // ---------------- behavioural model ----------------
  longint unsigned acc  [NUM_CH][ORDER];
  longint unsigned hist [NUM_CH][ORDER];
  logic [OUT_W-1:0] m_field [NUM_CH];
  logic [OUT_W-1:0] m_mon;
  logic [3:0] m_active;
  int  m_cnt;
  bit  m_valid;
  bit  model_ok = 0;

  function automatic logic [3:0] clampd(input logic [3:0] d);
    if (d == 0) return 4'd1;
    if (d > MAXL) return 4'(MAXL);
    return d;
  endfunction

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic model_step();
    longint unsigned y;
    cyc++;
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < ORDER; s++) begin
          acc[c][s]  = 0;
          hist[c][s] = 0;
        end
        m_field[c] = '0;
      end
      m_cnt = 0; m_valid = 0; m_mon = '0;
      m_active = clampd(decim_log2);
      model_ok = 1;
    end else if (model_ok) begin
      m_mon = (int'(digital_monitor_sel) < NUM_CH) ? m_field[digital_monitor_sel] : '0;
      m_valid = 0;
      if (enable) begin
        if (m_cnt == (1 << m_active) - 1) begin
          for (int c = 0; c < NUM_CH; c++) begin
            // ORDER-th backward difference of the decimated last-stage samples
            y = acc[c][ORDER-1];
            for (int k = 1; k <= ORDER; k++) begin
              if (k % 2 == 1) y = y - longint'(binom(ORDER, k)) * hist[c][k-1];
              else            y = y + longint'(binom(ORDER, k)) * hist[c][k-1];
            end
            for (int k = ORDER - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = acc[c][ORDER-1];
            m_field[c] = y[OUT_W-1:0];
          end
          m_valid  = 1;
          m_active = clampd(decim_log2);
          m_cnt    = 0;
        end else begin
          m_cnt++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
          for (int s = ORDER - 1; s > 0; s--) acc[c][s] = acc[c][s] + acc[c][s-1];
          acc[c][0] = acc[c][0] + longint'(in[c]);
        end
      end
    end
  endtask

  // scoreboard: model advances on each edge, DUT compared 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (model_ok) begin
        int bad;
        bad = -1;
        for (int c = 0; c < NUM_CH; c++) if (fld(c) !== m_field[c] && bad < 0) bad = c;
        n_checks++;
        if (bad >= 0) begin
          n_fail++;
          $display("FAIL out_field[%0d]: got %0d expected %0d (cycle %0d)",
                   bad, fld(bad), m_field[bad], cyc);
        end
        chk("out_valid", longint'(out_valid), longint'(m_valid));
        chk("active_decim_log2", longint'(active_decim_log2), longint'(m_active));
        chk("monitor_out", longint'(monitor_out), longint'(m_mon));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_strobe(input int maxc, input string nm, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (out_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no strobe within %0d cycles", nm, maxc);
    end
  endtask

  initial begin
    int s0, s1, s2, seen, k0;
    reset_n = 1'b0; enable = 1'b1; in = '1; decim_log2 = 4'd8;
    digital_monitor_sel = '0;
    tick();
    chk("reset_out0", longint'(fld(0)), 0);
    chk("reset_valid", longint'(out_valid), 0);
    chk("reset_active", longint'(active_decim_log2), 8);
    reset_n = 1'b1;

    // all ones, R=256: steady value R^3 from the 4th strobe
    for (int i = 0; i < 4; i++) wait_strobe(300, "ones_strobe", s0);
    seen = 0;
    for (int c = 0; c < NUM_CH; c++) if (fld(c) != 25'd16777216) seen++;
    chk("ones_r256_fields_bad", seen, 0);
    wait_strobe(300, "ones_strobe5", s1);
    chk("ones_r256_spacing", s1 - s0, 256);
    chk("ones_r256_value", longint'(fld(23)), 16777216);

    // zero input, R=4
    in = '0; decim_log2 = 4'd2;
    for (int i = 0; i < 10; i++) wait_strobe(300, "zero_strobe", s0);
    wait_strobe(10, "zero_strobe2", s1);
    chk("zero_spacing", s1 - s0, 4);
    seen = 0;
    for (int c = 0; c < NUM_CH; c++) if (fld(c) != 0) seen++;
    chk("zero_fields_bad", seen, 0);

    // ch0 alternating, ch1 ones, R=4
    digital_monitor_sel = 5'd1;
    for (int i = 0; i < 48; i++) begin
      in = NUM_CH'($urandom) & ~NUM_CH'(3);
      in[0] = i[0];
      in[1] = 1'b1;
      tick();
    end
    s0 = -1;
    for (int i = 0; i < 8 && s0 < 0; i++) begin
      in[0] = ~in[0];
      tick();
      if (out_valid) s0 = cyc;
    end
    chk("alt_strobe_found", (s0 >= 0) ? 1 : 0, 1);
    chk("alt_field0", longint'(fld(0)), 32);
    chk("alt_field1", longint'(fld(1)), 64);
    in[0] = ~in[0];
    tick();
    chk("alt_monitor_lag", longint'(monitor_out), 64);

    // decimation change mid-frame
    in = '1; decim_log2 = 4'd8;
    wait_strobe(10, "chg_strobe0", s0);
    for (int i = 0; i < 100; i++) tick();
    decim_log2 = 4'd4;
    wait_strobe(300, "chg_strobe1", s1);
    chk("chg_frame_256", s1 - s0, 256);
    chk("chg_active4", longint'(active_decim_log2), 4);
    wait_strobe(40, "chg_strobe2", s2);
    chk("chg_frame_16", s2 - s1, 16);
    decim_log2 = 4'd0;
    wait_strobe(40, "clamp0_strobe", s1);
    chk("clamp0_active", longint'(active_decim_log2), 1);
    wait_strobe(10, "clamp0_strobe2", s2);
    chk("clamp0_spacing", s2 - s1, 2);
    decim_log2 = 4'd15;
    wait_strobe(10, "clamp15_strobe", s1);
    chk("clamp15_active", longint'(active_decim_log2), 8);

    // enable gap, R=8, all ones
    decim_log2 = 4'd3;
    for (int i = 0; i < 6; i++) wait_strobe(300, "gap_pre", s0);
    chk("gap_pre_value", longint'(fld(0)), 512);
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (out_valid) seen++; end
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin tick(); if (out_valid) seen++; end
    chk("gap_no_strobe", seen, 0);
    enable = 1'b1;
    wait_strobe(20, "gap_post", s1);
    chk("gap_delay", s1 - s0, 58);
    chk("gap_value", longint'(fld(0)), 512);

    // one-cycle reset mid-frame, then R=32
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b0; decim_log2 = 4'd5; in = NUM_CH'($urandom);
    tick();
    k0 = cyc;
    chk("rst_out_zero", (out == '0) ? 1 : 0, 1);
    chk("rst_valid_zero", longint'(out_valid), 0);
    chk("rst_monitor_zero", longint'(monitor_out), 0);
    chk("rst_active", longint'(active_decim_log2), 5);
    reset_n = 1'b1;
    wait_strobe(40, "rst_first_strobe", s1);
    chk("rst_first_strobe_delay", s1 - k0, 32);

    // randomized stimulus checked by the model every cycle
    for (int i = 0; i < 2500; i++) begin
      in = NUM_CH'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 40) == 0) decim_log2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 20) == 0) digital_monitor_sel = SEL_W'($urandom_range(0, 31));
      reset_n = ($urandom_range(0, 799) != 0);
      tick();
    end
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
